toggle_counter: RTL
===================

# toggle_counter

- Synchronous modulo-N up/down counter built on a bank of toggle (T) flip-flops.
- Each cycle it computes the per-bit toggle mask `T` and applies it to its own state register, so `Q_next = Q ^ T`.
- It exports that mask so downstream `tflipflop` banks can be driven in lock-step.
- It is the next stage after the single `tflipflop` cell: it generates the T inputs a chain of those cells consumes, and provides terminal-count/wrap outputs for cascading decades.

## Interface
Parameters:
- WIDTH, 4, counter width in bits
- MODULUS, 10, count sequence length; legal range 2..2^WIDTH; count runs 0..MODULUS-1

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high; sampled on rising edge of Clock
- En  input  1  count enable
- Up  input  1  direction: 1 = increment, 0 = decrement
- Load  input  1  synchronous parallel load
- D  input  WIDTH  load value
- Q  output  WIDTH  registered count
- T  output  WIDTH  combinational toggle mask applied at the next edge
- Tc  output  1  combinational terminal count
- Wrap  output  1  registered one-cycle pulse after a wrap-around

## Operation
- Priority at each rising edge is Reset > Load > En; with none active, Q holds and T = 0.
- **Reset:**
  - Q = 0 and Wrap = 0.
  - T = Q while Reset is high, so the toggle clears every set bit.
- **Load:**
  - If D < MODULUS, Q = D.
  - If D >= MODULUS, Q = 0; out-of-range values are never stored.
  - T = Q ^ (loaded value). Wrap = 0.
  - En and Up are ignored during Load.
- **Count, En=1, Up=1:**
  - Q = MODULUS-1 goes to 0 (wrap).
  - Otherwise Q goes to Q+1.
- **Count, En=1, Up=0:**
  - Q = 0 goes to MODULUS-1 (wrap).
  - Otherwise Q goes to Q-1.
- **T computation:** T always equals Q ^ Q_next, derived from the priority above. State updates only through Q <= Q ^ T.
  - For MODULUS = 2^WIDTH, T reduces to the classic ripple-toggle equations:
    - up: T[i] = &Q[i-1:0]
    - down: T[i] = ~|Q[i-1:0]
    - T[0] = 1 in both directions.
  - For any other MODULUS, the wrap value overrides those equations.
- **Tc:** Tc = En & ~Load & ~Reset & (Up ? Q == MODULUS-1 : Q == 0).
  - Tc feeds the En of the next cascaded stage.
- **Wrap:** registered Tc. High for exactly one cycle following every edge at which a wrap occurred.
- **Direction change:** a change of Up takes effect at the next edge with no extra latency. A wrap is decided by the Up value sampled at that edge.

## Timing
- Q latency: one edge after Reset, Load or En is sampled.
- T and Tc: zero latency (combinational from Q, En, Up, Load, D, Reset). They are stable before the edge for a downstream T-FF bank clocked by the same Clock.
- Wrap: asserted in the cycle after the wrapping edge and deasserted one cycle later, unless another wrap occurs.
- **Reset mid-count:** clears Q and kills a pending Wrap at the same edge. Wrap is 0 in the next cycle even if Tc was high.
- **Load and En together:** Load wins, no wrap, Wrap = 0 next cycle.
- **En held low:** Q, T = 0, Tc = 0 and Wrap (after one cycle) remain static indefinitely.
- **Power-up:** outputs are undefined until the first edge with Reset = 1. The bench must apply Reset for at least one edge.

## Test plan
All scenarios use WIDTH=4 and MODULUS=10.

1. **Reset clears state.** Reset=1 for one edge with Q=7 → Q=0 and Wrap=0 next cycle. T=0111 during the Reset cycle.
2. **Up count and wrap.** Reset then En=1, Up=1 for 12 edges → Q runs 1,2,…,9,0,1,2.
   - Tc=1 only while Q=9.
   - Wrap=1 for exactly the one cycle after Q goes 9→0.
   - T=1001 when Q=9.
3. **Down count and wrap.** Load D=2, then En=1, Up=0 → Q runs 2,1,0,9,8.
   - Tc=1 while Q=0.
   - Wrap pulses once after 0→9, with T=1001 at that edge.
4. **Load behaviour.**
   - Load D=5 → Q=5 and T=0101 before the edge, starting from Q=0.
   - Load D=12 → Q=0.
   - Load=1 with En=1, Up=1 at Q=9 → Q=D and no Wrap.
5. **Priority and direction.**
   - At Q=9, Reset=1 with En=1 → Q=0 and Wrap=0.
   - At Q=4, toggle Up every edge with En=1 → Q alternates 5,4,5,4.
6. **Hold and cascade.**
   - En=0 for 5 edges at Q=6 → Q stays 6, T=0, Tc=0.
   - Two instances with stage1.En = stage0.Tc, counted 0→99 → stage1 increments exactly once per stage0 wrap.

Source files
------------

// File: rtl/toggle_counter.sv
// rtl/toggle_counter.sv - modulo-N up/down counter built on a bank of toggle flip-flops
//
// Ports:
//   Clock  rising-edge clock
//   Reset  synchronous active-high reset (highest priority)
//   En     count enable
//   Up     direction: 1 = increment, 0 = decrement
//   Load   synchronous parallel load (beats En)
//   D      load value; values >= MODULUS load as 0
//   Q      registered count, 0..MODULUS-1
//   T      combinational toggle mask applied at the next edge (Q_next = Q ^ T)
//   Tc     combinational terminal count, drives En of the next cascaded stage
//   Wrap   registered one-cycle pulse after a wrap-around edge

module toggle_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] T,
  output logic             Tc,
  output logic             Wrap
);

  // Terminal value of the up sequence, and MODULUS widened by one bit so
  // that MODULUS = 2^WIDTH still compares correctly against D.
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] up_ripple;
  logic [WIDTH-1:0] down_ripple;
  logic [WIDTH-1:0] up_mask;
  logic [WIDTH-1:0] down_mask;
  logic [WIDTH-1:0] count_mask;
  logic [WIDTH-1:0] load_value;
  logic             at_top;
  logic             at_zero;
  logic             load_ok;

  // Classic ripple-toggle equations: bit i toggles when every lower bit is 1
  // (counting up) or every lower bit is 0 (counting down). Bit 0 always
  // toggles. The running AND chains are built LSB first.
  always_comb begin : ripple
    logic ones_run;
    logic zeros_run;
    ones_run    = 1'b1;
    zeros_run   = 1'b1;
    up_ripple   = '0;
    down_ripple = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up_ripple[i]   = ones_run;
      down_ripple[i] = zeros_run;
      ones_run       = ones_run & Q[i];
      zeros_run      = zeros_run & ~Q[i];
    end
  end

  assign at_top  = (Q == LAST);
  assign at_zero = (Q == '0);

  // Wrap overrides the ripple equations. Going up from LAST to 0 the mask is
  // Q itself; going down from 0 to LAST the mask is LAST. For a full binary
  // modulus these coincide with the ripple result, so no special case.
  assign up_mask    = at_top  ? Q    : up_ripple;
  assign down_mask  = at_zero ? LAST : down_ripple;
  assign count_mask = Up ? up_mask : down_mask;

  // Out-of-range load values collapse to 0 so Q never leaves 0..MODULUS-1.
  assign load_ok    = ({1'b0, D} < MOD_EXT);
  assign load_value = load_ok ? D : '0;

  // Toggle mask follows the Reset > Load > En priority; idle gives 0.
  always_comb begin
    T = '0;
    if (Reset) begin
      T = Q;
    end else if (Load) begin
      T = Q ^ load_value;
    end else if (En) begin
      T = count_mask;
    end
  end

  assign Tc = En & ~Load & ~Reset & (Up ? at_top : at_zero);

  // The reset branch assigns 0 directly rather than Q ^ Q so that an
  // unknown power-up state is cleared; the result is identical once Q is known.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Q    <= '0;
      Wrap <= 1'b0;
    end else begin
      Q    <= Q ^ T;
      Wrap <= Tc;
    end
  end

endmodule
